// File: rtl/sprite_anim.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sprite_anim : two-stage sprite pixel pipeline with frame-animation control |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module sprite_anim #(
  parameter int X_SIZE    = 26,
  parameter int Y_SIZE    = 32,
  parameter int FRAMES    = 4,
  parameter int FRAME_DIV = 8,
  parameter int ADDR_W    = 12,
  localparam int FW       = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       ix,
  input  logic [10:0]       iy,
  input  logic [10:0]       px,
  input  logic [10:0]       py,
  input  logic              frame_tick,
  input  logic              anim_en,
  input  logic              one_shot,
  input  logic              restart,
  input  logic              flip_h,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [12:0]       rom_data,
  output logic [7:0]        oR,
  output logic [7:0]        oG,
  output logic [7:0]        oB,
  output logic              mask,
  output logic [FW-1:0]     frame,
  output logic              done
);

  localparam int              c_DW       = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FW-1:0]   c_LAST     = FW'(FRAMES - 1);
  localparam logic [c_DW-1:0] c_DIV_TOP  = c_DW'(FRAME_DIV - 1);
  localparam logic [11:0]     c_XS       = 12'(X_SIZE);
  localparam logic [11:0]     c_YS       = 12'(Y_SIZE);
  localparam logic [10:0]     c_X_LAST   = 11'(X_SIZE - 1);
  localparam bit              c_MULTI    = (FRAMES > 1);

  logic [FW-1:0]     r_frame;
  logic [c_DW-1:0]   r_div;
  logic              r_done;

  logic              r_in_box1;
  logic [7:0]        r_ix1;
  logic [7:0]        r_iy1;

  logic              w_in_box;
  logic [10:0]       w_lx;
  logic [10:0]       w_ly;
  logic [10:0]       w_lx_eff;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_diag;

  logic              w_at_last;
  logic              w_hold;
  logic              w_tick;
  logic              w_term;
  logic [FW-1:0]     w_frame_nxt;
  logic [c_DW-1:0]   w_div_nxt;
  logic              w_done_nxt;

  // Box bounds are formed at 12 bits so an origin near the right/bottom edge cannot wrap.
  assign w_in_box = (ix >= px) && ({1'b0, ix} < ({1'b0, px} + c_XS)) &&
                    (iy >= py) && ({1'b0, iy} < ({1'b0, py} + c_YS));
  assign w_lx     = ix - px;
  assign w_ly     = iy - py;
  assign w_lx_eff = flip_h ? (c_X_LAST - w_lx) : w_lx;
  assign w_addr   = ADDR_W'(r_frame) * ADDR_W'(X_SIZE * Y_SIZE)
                  + ADDR_W'(w_ly) * ADDR_W'(X_SIZE)
                  + ADDR_W'(w_lx_eff);
  assign w_diag   = r_ix1 + r_iy1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr  <= '0;
      r_in_box1 <= 1'b0;
      r_ix1     <= '0;
      r_iy1     <= '0;
    end else begin
      rom_addr  <= w_in_box ? w_addr : '0;
      r_in_box1 <= w_in_box;
      r_ix1     <= ix[7:0];
      r_iy1     <= iy[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oR   <= '0;
      oG   <= '0;
      oB   <= '0;
      mask <= 1'b0;
    end else if (r_in_box1) begin
      oR   <= {rom_data[11:8], 4'b0000};
      oG   <= {rom_data[7:4], 4'b0000};
      oB   <= {rom_data[3:0], 4'b0000};
      mask <= rom_data[12];
    end else begin
      oR   <= r_ix1;
      oG   <= r_iy1;
      oB   <= w_diag;
      mask <= 1'b0;
    end
  end

  // A single-frame sprite is always "at last", so it only holds once done has latched.
  assign w_at_last = (r_frame == c_LAST);
  assign w_hold    = one_shot && w_at_last && (c_MULTI || r_done);
  assign w_tick    = frame_tick && anim_en && !w_hold;
  assign w_term    = w_tick && (r_div == c_DIV_TOP);

  always_comb begin
    w_frame_nxt = r_frame;
    w_div_nxt   = r_div;
    if (w_tick) begin
      if (w_term) begin
        w_div_nxt   = '0;
        w_frame_nxt = w_at_last ? '0 : r_frame + FW'(1);
      end else begin
        w_div_nxt   = r_div + c_DW'(1);
      end
    end
    w_done_nxt = one_shot && (w_frame_nxt == c_LAST) && (c_MULTI || r_done || w_term);
  end

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_frame <= '0;
      r_div   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_frame <= w_frame_nxt;
      r_div   <= w_div_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign frame = r_frame;
  assign done  = r_done;

endmodule
`default_nettype wire

// File: doc/sprite_anim.md
SPRITE_ANIM -- requirements
Module: sprite_anim

Interface
REQ-001: Parameter X_SIZE, default 26, sprite width in pixels.
REQ-002: Parameter Y_SIZE, default 32, sprite height in pixels.
REQ-003: Parameter FRAMES, default 4, number of animation frames stored in ROM (>=1).
REQ-004: Parameter FRAME_DIV, default 8, number of frame_tick pulses per animation step (>=1).
REQ-005: Parameter ADDR_W, default 12, ROM address width; SHALL satisfy 2^ADDR_W >= FRAMES*X_SIZE*Y_SIZE.
REQ-006: clk  input  1  the only clock; all logic SHALL be on its rising edge.
REQ-007: rst  input  1  reset; synchronous, active-high.
REQ-008: ix, iy  input  11 each  current scan pixel coordinate.
REQ-009: px, py  input  11 each  sprite top-left origin on screen.
REQ-010: frame_tick  input  1  one-cycle pulse per video frame, issued in vblank.
REQ-011: anim_en  input  1  1 = animation advances; 0 = frame held.
REQ-012: one_shot  input  1  0 = loop mode; 1 = stop on last frame.
REQ-013: restart  input  1  one-cycle pulse; returns the animation to frame 0.
REQ-014: flip_h  input  1  1 = mirror sprite horizontally.
REQ-015: rom_addr  output  ADDR_W  registered ROM address.
REQ-016: rom_data  input  13  {alpha, R4, G4, B4}, valid one cycle after rom_addr.
REQ-017: oR, oG, oB  output  8 each  pixel colour.
REQ-018: mask  output  1  1 = sprite pixel opaque at this position.
REQ-019: frame  output  clog2(FRAMES) (min 1)  current animation frame index.
REQ-020: done  output  1  one_shot animation has reached its last frame.

Function
REQ-021: Stage 1 SHALL compute in_box = (ix>=px)&&(ix<px+X_SIZE)&&(iy>=py)&&(iy<py+Y_SIZE), with the sums formed at 12 bits so an origin near 2047 does not wrap.
REQ-022: Stage 1 SHALL compute lx=ix-px and ly=iy-py; with flip_h=1, lx SHALL be replaced by X_SIZE-1-lx.
REQ-023: Stage 1 SHALL register rom_addr = frame*X_SIZE*Y_SIZE + ly*X_SIZE + lx when in_box, and 0 otherwise, and delay in_box, ix and iy one cycle.
REQ-024: Stage 2 SHALL register the outputs; total latency from ix/iy to oR/oG/oB/mask SHALL be exactly 2 cycles.
REQ-025: In-box pixel: oR={R4,4'b0000}, oG={G4,4'b0000}, oB={B4,4'b0000}, mask=alpha.
REQ-026: Out-of-box pixel: oR=ix[7:0], oG=iy[7:0], oB=(ix+iy)[7:0] using the delayed coordinates, mask=0.
REQ-027: A divider counter SHALL count frame_tick pulses while anim_en=1; on the FRAME_DIV-th pulse it SHALL clear and advance frame by one.
REQ-028: Loop mode: frame SHALL wrap from FRAMES-1 to 0.
REQ-029: One-shot mode: at FRAMES-1, frame and divider SHALL hold and done SHALL be 1; done SHALL be 0 in all other cases.
REQ-030: restart SHALL clear frame, divider and done on the next edge and SHALL take priority over a simultaneous frame_tick.
REQ-031: anim_en=0 SHALL freeze both the divider and frame; frame_tick pulses arriving then SHALL be ignored.
REQ-032: frame SHALL change only on a frame_tick or restart edge, so no frame switch occurs during active scan.
REQ-033: With FRAMES=1, frame SHALL stay 0; done SHALL become 1 on the first divider terminal count when one_shot=1.

Reset
REQ-034: While rst=1: rom_addr, oR, oG, oB, mask, frame, done, the divider and all pipeline registers SHALL be 0.
REQ-035: rst SHALL dominate restart and frame_tick; after rst, the first valid output SHALL appear 2 cycles after the first sampled coordinate.

Verification
REQ-036: px=100, py=50, ix=100, iy=50, frame=0, flip_h=0 -> rom_addr=0 after 1 cycle; oR/oG/oB/mask from rom_data after 2 cycles.
REQ-037: Same origin, ix=125, flip_h=1 -> rom_addr=0; with flip_h=0 -> rom_addr=25.
REQ-038: ix=99, iy=60, px=100 -> mask=0, oR=99, oG=60, oB=159 after 2 cycles; also px=2040, ix=2046 -> in_box=1 with no wrap.
REQ-039: FRAME_DIV=8, FRAMES=4, loop mode, 32 ticks -> frame sequence 0,1,2,3,0; frame=1 with X=26,Y=32 -> in-box base address 832.
REQ-040: one_shot=1, 40 ticks -> frame holds at 3 with done=1; restart together with frame_tick -> frame=0, done=0.
REQ-041: rst asserted mid-scan with frame=2 -> all outputs 0 on the next edge; anim_en=0 with ticks applied -> frame unchanged.
